branch_resolve_tracker: RTL and testbench
=========================================

Name: branch_resolve_tracker

Overview:
- Consumer and updater end of the branch predictor interface.
- Records every prediction issued at fetch in an in-flight queue.
- Matches each entry, in order, against the actual outcome resolved in EX.
- Emits the counter/history update pulse (corrected_en/corrected_result) back to the predictor, plus the pipeline redirect on mispredict. Sits between the EX branch comparator and the fetch-stage predictor/PC mux.

Parameters:
- DEPTH, 4, in-flight queue entries; power of two, min 2.
- JUMP_STATUS_COUNTER_WIDTH, 2, width of the stored predictor counter snapshot.
- STAT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- PL_stall  in  1  pipeline stall; blocks push and pop.
- pred_valid  in  1  fetch issued a conditional-branch prediction this cycle.
- pred_pc  in  32  PC of the predicted branch.
- pred_taken  in  1  predicted direction.
- pred_target  in  32  predicted target (valid when pred_taken).
- pred_count  in  JUMP_STATUS_COUNTER_WIDTH  predictor counter at prediction time.
- res_valid  in  1  EX resolved the oldest in-flight branch.
- res_taken  in  1  actual direction.
- res_target  in  32  actual taken target.
- corrected_en  out  1  one-cycle pulse to predictor: update counter/history.
- corrected_result  out  1  actual direction for that update.
- redirect_en  out  1  one-cycle pulse: flush younger instructions, refetch.
- redirect_pc  out  32  refetch address.
- full  out  1  queue full; fetch must stall prediction.
- empty  out  1  queue empty.
- res_error  out  1  sticky; res_valid while empty.
- branch_cnt  out  STAT_WIDTH  resolved branches, saturating.
- mispredict_cnt  out  STAT_WIDTH  mispredicts, saturating.

Behaviour:
- Reset, async, on rst high:
  - pointers and occupancy 0; empty=1, full=0.
  - corrected_en=0, corrected_result=0, redirect_en=0, redirect_pc=0.
  - res_error=0, both counters 0; FSM = RUN.
  - Reset mid-flush abandons the flush.
- Entry contents: {pc, taken, target, count}.
- Push: on pred_valid && !PL_stall && !full && state==RUN. pred_valid while full is dropped; fetch must honour full.
- Pop:
  - Occurs on res_valid && !PL_stall && !empty.
  - Compares against head entry. Mispredict = (res_taken != taken) || (res_taken && res_target != target).
- Latency: all outputs registered, valid exactly one cycle after the pop cycle.
  - corrected_en=1 on every pop; corrected_result=res_taken.
  - On mispredict: redirect_en=1; redirect_pc = res_taken ? res_target : pc+4 (32-bit wrap at 0xFFFFFFFC -> 0).
  - branch_cnt increments on every pop; mispredict_cnt increments on mispredict. Both saturate at all-ones.
- Simultaneous push and pop while not full/empty: occupancy unchanged. Push while full and pop same cycle: push still dropped, since full is registered.
- FSM:
  - RUN -> FLUSH on a mispredicting pop.
  - FLUSH lasts exactly one cycle: pointers reset, occupancy 0, all younger entries discarded. Any pred_valid in the pop cycle or the FLUSH cycle is ignored.
  - FLUSH -> RUN unconditionally.
  - res_valid in FLUSH is ignored and sets res_error.
- res_error sets on res_valid && !PL_stall && empty; clears only on reset.
- Pointer width is log2(DEPTH)+1, with wrap-around via the MSB toggle. full/empty are derived from the pointers.
- PL_stall freezes the queue only; output pulses still deassert after one cycle.

Decomposition:
- Shared package constants:
  - JUMP_STATUS_COUNTER_WIDTH default.
  - PC increment constant 32'd4.
  - Entry field widths and packed entry layout.
  - FSM state encodings RUN/FLUSH.
- One sub-module: resolve_queue, a parameterised synchronous FIFO with flush input, full/empty and head read.
- Mispredict compare and stats live in the top.

Test Plan:
- Reset: assert rst mid-run with 3 entries queued -> immediately empty=1, redirect_en=0, branch_cnt=0.
- Correct not-taken: push pc=0x100 taken=0, then res_valid res_taken=0 -> next cycle corrected_en=1, corrected_result=0, redirect_en=0, branch_cnt=1.
- Direction mispredict with younger entries:
  - Push 0x100 (taken=0), 0x200, 0x300; resolve 0x100 with res_taken=1, res_target=0x400.
  - Next cycle redirect_en=1, redirect_pc=0x400, mispredict_cnt=1.
  - After FLUSH, empty=1 and the 0x200/0x300 entries are never resolved.
- Target mispredict: push taken=1 target=0x500; resolve taken=1 target=0x540 -> redirect_pc=0x540. Predicted-taken/actual-not-taken at pc=0xFFFFFFFC -> redirect_pc=0x0.
- Full/stall/wrap: push 4 -> full=1; 5th pred_valid dropped. Pop and push together for 10 cycles -> FIFO order preserved across wrap. PL_stall=1 blocks both.
- Error/saturation: res_valid when empty -> res_error=1 stays sticky. With STAT_WIDTH=2, 5 pops -> branch_cnt holds 3.

Source files
------------

// File: rtl/branch_resolve_tracker_pkg.sv
// branch_resolve_tracker_pkg: shared constants, entry layout and FSM encoding
package branch_resolve_tracker_pkg;
  localparam int DEF_COUNTER_WIDTH = 2;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic taken;
    logic [PC_W-1:0] target;
    logic [DEF_COUNTER_WIDTH-1:0] count;
  } entry_t;
  function automatic int entry_w(input int cw);
    return 2 * PC_W + 1 + cw;
  endfunction
endpackage

// File: rtl/branch_resolve_tracker_queue.sv
// resolve_queue: in-order FIFO of in-flight predictions with flush and head read
module resolve_queue #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign dout = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  // pointers: flush discards every queued entry at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= push ? wp + ONE : wp;
      rp <= pop ? rp + ONE : rp;
    end
  end
  // storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/branch_resolve_tracker.sv
// branch_resolve_tracker: matches in-flight predictions to EX outcomes, updates predictor, redirects
module branch_resolve_tracker
  import branch_resolve_tracker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int JUMP_STATUS_COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int STAT_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 PL_stall,
  input  logic                                 pred_valid,
  input  logic [31:0]                          pred_pc,
  input  logic                                 pred_taken,
  input  logic [31:0]                          pred_target,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] pred_count,
  input  logic                                 res_valid,
  input  logic                                 res_taken,
  input  logic [31:0]                          res_target,
  output logic                                 corrected_en,
  output logic                                 corrected_result,
  output logic                                 redirect_en,
  output logic [31:0]                          redirect_pc,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 res_error,
  output logic [STAT_WIDTH-1:0]                branch_cnt,
  output logic [STAT_WIDTH-1:0]                mispredict_cnt
);
  localparam int EW = entry_w(JUMP_STATUS_COUNTER_WIDTH);
  localparam logic [STAT_WIDTH-1:0] ONE = 1;
  state_t state, state_nx;
  logic flush, run, push, pop, mis, err_set;
  logic [EW-1:0] head;
  logic [31:0] h_pc, h_tgt;
  logic h_taken;
  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] cnt_unused;
  assign {h_pc, h_taken, h_tgt, cnt_unused} = head;
  assign pop = res_valid && !PL_stall && !empty && run;
  assign mis = (res_taken != h_taken) || (res_taken && res_target != h_tgt);
  assign push = pred_valid && !PL_stall && !full && run && !(pop && mis);
  assign err_set = res_valid && !PL_stall && (empty || flush);
  resolve_queue #(.W(EW), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({pred_pc, pred_taken, pred_target, pred_count}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else state <= state_nx;
  end
  // a mispredicting pop starts a one-cycle flush of the younger entries
  always_comb begin
    state_nx = (state == RUN && pop && mis) ? FLUSH : RUN;
  end
  // state decode
  always_comb begin
    flush = state == FLUSH;
    run = state == RUN;
  end
  // registered predictor update, redirect, error flag and saturating stats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corrected_en     <= 1'b0;
      corrected_result <= 1'b0;
      redirect_en      <= 1'b0;
      redirect_pc      <= '0;
      res_error        <= 1'b0;
      branch_cnt       <= '0;
      mispredict_cnt   <= '0;
    end else begin
      corrected_en     <= pop;
      corrected_result <= pop ? res_taken : corrected_result;
      redirect_en      <= pop && mis;
      redirect_pc      <= (pop && mis) ? (res_taken ? res_target : h_pc + PC_INC) : redirect_pc;
      res_error        <= res_error || err_set;
      branch_cnt       <= (pop && !(&branch_cnt)) ? branch_cnt + ONE : branch_cnt;
      mispredict_cnt   <= (pop && mis && !(&mispredict_cnt)) ? mispredict_cnt + ONE : mispredict_cnt;
    end
  end
endmodule

// File: tb/tb_branch_resolve_tracker.sv
// tb_branch_resolve_tracker: random and directed checks against a queue-based reference model
module tb_branch_resolve_tracker;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, PL_stall = 1'b0;
  logic pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] pred_pc = '0, pred_target = '0, res_target = '0;
  logic [1:0] pred_count = '0;
  logic corrected_en, corrected_result, redirect_en, full, empty, res_error;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, mispredict_cnt;
  logic d2_ce, d2_cr, d2_re, d2_full, d2_empty, d2_err;
  logic [31:0] d2_rpc;
  logic [1:0] d2_bcnt, d2_mcnt;

  branch_resolve_tracker #(.DEPTH(DEPTH), .JUMP_STATUS_COUNTER_WIDTH(2), .STAT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .PL_stall(PL_stall),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_count(pred_count),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .corrected_en(corrected_en), .corrected_result(corrected_result),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .full(full), .empty(empty), .res_error(res_error),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_resolve_tracker #(.DEPTH(DEPTH), .JUMP_STATUS_COUNTER_WIDTH(2), .STAT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .PL_stall(PL_stall),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_count(pred_count),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .corrected_en(d2_ce), .corrected_result(d2_cr),
    .redirect_en(d2_re), .redirect_pc(d2_rpc),
    .full(d2_full), .empty(d2_empty), .res_error(d2_err),
    .branch_cnt(d2_bcnt), .mispredict_cnt(d2_mcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        t;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];
  logic m_flush = 1'b0, m_err = 1'b0, e_ce = 1'b0, e_cr = 1'b0, e_re = 1'b0;
  logic [31:0] e_rpc = '0;
  int bcnt = 0, mcnt = 0;
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int mx);
    return 32'(v > mx ? mx : v);
  endfunction

  task automatic check_all();
    chk("corrected_en", {31'b0, corrected_en}, {31'b0, e_ce});
    if (e_ce) chk("corrected_result", {31'b0, corrected_result}, {31'b0, e_cr});
    chk("redirect_en", {31'b0, redirect_en}, {31'b0, e_re});
    if (e_re) chk("redirect_pc", redirect_pc, e_rpc);
    chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
    chk("full", {31'b0, full}, {31'b0, q.size() == DEPTH});
    chk("res_error", {31'b0, res_error}, {31'b0, m_err});
    chk("branch_cnt", {16'b0, branch_cnt}, sat(bcnt, 65535));
    chk("mispredict_cnt", {16'b0, mispredict_cnt}, sat(mcnt, 65535));
    chk("sat2_branch_cnt", {30'b0, d2_bcnt}, sat(bcnt, 3));
    chk("sat2_mispredict_cnt", {30'b0, d2_mcnt}, sat(mcnt, 3));
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 1'b0; m_err = 1'b0; e_ce = 1'b0; e_cr = 1'b0; e_re = 1'b0;
    e_rpc = '0; bcnt = 0; mcnt = 0;
  endtask

  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                      input logic rv, input logic rt, input logic [31:0] rtg, input logic st);
    logic emp, ful, pop_m, mis_m, push_m;
    ent_t h;
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    pred_count = 2'($urandom);
    res_valid = rv; res_taken = rt; res_target = rtg; PL_stall = st;
    emp = q.size() == 0;
    ful = q.size() == DEPTH;
    h = emp ? '{32'h0, 1'b0, 32'h0} : q[0];
    pop_m = rv && !st && !emp && !m_flush;
    mis_m = pop_m && ((rt != h.t) || (rt && rtg != h.tgt));
    if (rv && !st && (emp || m_flush)) m_err = 1'b1;
    push_m = pv && !st && !ful && !m_flush && !mis_m;
    e_ce = pop_m;
    if (pop_m) e_cr = rt;
    e_re = mis_m;
    if (mis_m) e_rpc = rt ? rtg : h.pc + 32'd4;
    if (pop_m) bcnt++;
    if (mis_m) mcnt++;
    if (m_flush) q.delete();
    else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back('{ppc, pt, ptg});
    end
    m_flush = mis_m;
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    step(1'b1, pc, t, tg, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rtg);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rt, rtg, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_empty", {31'b0, empty}, 32'd1);
    chk("reset_full", {31'b0, full}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'h0);
    chk("reset_res_error", {31'b0, res_error}, 32'd0);
    rst = 1'b0;
    // correct not-taken prediction
    push(32'h100, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    chk("nt_corrected_en", {31'b0, corrected_en}, 32'd1);
    chk("nt_corrected_result", {31'b0, corrected_result}, 32'd0);
    chk("nt_redirect_en", {31'b0, redirect_en}, 32'd0);
    chk("nt_branch_cnt", {16'b0, branch_cnt}, 32'd1);
    // asynchronous reset with three entries queued
    push(32'h10, 1'b0, 32'h0);
    push(32'h20, 1'b1, 32'h80);
    push(32'h30, 1'b0, 32'h0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_empty", {31'b0, empty}, 32'd1);
    chk("midrst_redirect_en", {31'b0, redirect_en}, 32'd0);
    chk("midrst_branch_cnt", {16'b0, branch_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // direction mispredict flushes younger entries
    push(32'h100, 1'b0, 32'h0);
    push(32'h200, 1'b0, 32'h0);
    push(32'h300, 1'b0, 32'h0);
    resolve(1'b1, 32'h400);
    chk("dir_redirect_en", {31'b0, redirect_en}, 32'd1);
    chk("dir_redirect_pc", redirect_pc, 32'h400);
    chk("dir_mispredict_cnt", {16'b0, mispredict_cnt}, 32'd1);
    step(1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("dir_flushed_empty", {31'b0, empty}, 32'd1);
    // target mispredict and pc+4 wrap
    push(32'h500, 1'b1, 32'h500);
    resolve(1'b1, 32'h540);
    chk("tgt_redirect_pc", redirect_pc, 32'h540);
    idle();
    push(32'hFFFF_FFFC, 1'b1, 32'h10);
    resolve(1'b0, 32'h0);
    chk("wrap_redirect_pc", redirect_pc, 32'h0);
    idle();
    // fill, drop when full, concurrent push/pop across wrap, stall
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
    chk("fill_full", {31'b0, full}, 32'd1);
    push(32'h9999, 1'b1, 32'h1);
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h2000 + 32'(i * 4), i[0], 32'h3000 + 32'(i), 1'b1, q[0].t, q[0].tgt, 1'b0);
    step(1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1, 1'b1);
    while (q.size() > 0) resolve(q[0].t, q[0].tgt);
    // resolve while empty is sticky
    resolve(1'b0, 32'h0);
    chk("err_set", {31'b0, res_error}, 32'd1);
    idle();
    idle();
    chk("err_sticky", {31'b0, res_error}, 32'd1);
    chk("sat2_holds", {30'b0, d2_bcnt}, 32'd3);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic pv, pt, rv, rt, st;
      logic [31:0] ppc, ptg, rtg;
      pv = 1'($urandom);
      pt = 1'($urandom);
      ppc = {$urandom} & 32'hFFFF_FFFC;
      ptg = {28'h0, 4'($urandom)} << 2;
      st = $urandom_range(0, 7) == 0;
      rv = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      rt = 1'($urandom);
      rtg = {28'h0, 4'($urandom)} << 2;
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt = q[0].t;
        rtg = q[0].t ? q[0].tgt : rtg;
      end
      step(pv, ppc, pt, ptg, rv, rt, rtg, st);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
